fetch_stage: RTL and testbench

//   Fetch (F) stage of the 5-stage pipelined RV32I core plus the F->D pipeline register.

---
 rtl/fetch_stage.sv | 112 +++++++++++
 tb/tb_fetch_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I fetch stage. Holds the program counter and the F->D pipeline register.
// Optional build macro FETCH_PERF_EN adds saturating stall/flush event counters.
module fetch_stage #(
   parameter int unsigned                 DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0]       RESET_PC   = '0,
   parameter logic [DATA_WIDTH-1:0]       NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    StallF,
   input  logic                    StallD,
   input  logic                    FlushD,
   input  logic                    PCSrcE,
   input  logic [DATA_WIDTH-1:0]   PCTargetE,
   input  logic [DATA_WIDTH-1:0]   InstrF,
`ifdef FETCH_PERF_EN
   output logic [31:0]             StallCountF,
   output logic [31:0]             FlushCountD,
`endif
   output logic [DATA_WIDTH-1:0]   PCF,
   output logic [DATA_WIDTH-1:0]   InstrD,
   output logic [DATA_WIDTH-1:0]   PCD,
   output logic [DATA_WIDTH-1:0]   PCPlus4D,
   output logic                    ValidD
);

   localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);
   localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);

   logic [DATA_WIDTH-1:0] r_pcf;
   logic [DATA_WIDTH-1:0] r_instr_d;
   logic [DATA_WIDTH-1:0] r_pc_d;
   logic [DATA_WIDTH-1:0] r_pc_plus4_d;
   logic                  r_valid_d;

   logic [DATA_WIDTH-1:0] w_pc_plus4;
   logic [DATA_WIDTH-1:0] w_target;
   logic [DATA_WIDTH-1:0] w_pc_next;

   // Single incrementer shared by the next-PC mux and the D register; wraps naturally.
   assign w_pc_plus4 = r_pcf + PC_STEP;
   assign w_target   = PCTargetE & ALIGN_MASK;

   always_comb begin
      w_pc_next = w_pc_plus4;
      if (PCSrcE) begin
         w_pc_next = w_target;
      end else if (StallF) begin
         w_pc_next = r_pcf;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pcf <= RESET_PC;
      end else begin
         r_pcf <= w_pc_next;
      end
   end

   // F->D register: flush inserts a bubble even while decode is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr_d    <= NOP_INSTR;
         r_pc_d       <= '0;
         r_pc_plus4_d <= '0;
         r_valid_d    <= 1'b0;
      end else if (FlushD) begin
         r_instr_d    <= NOP_INSTR;
         r_pc_d       <= '0;
         r_pc_plus4_d <= '0;
         r_valid_d    <= 1'b0;
      end else if (!StallD) begin
         r_instr_d    <= InstrF;
         r_pc_d       <= r_pcf;
         r_pc_plus4_d <= w_pc_plus4;
         r_valid_d    <= 1'b1;
      end
   end

   assign PCF      = r_pcf;
   assign InstrD   = r_instr_d;
   assign PCD      = r_pc_d;
   assign PCPlus4D = r_pc_plus4_d;
   assign ValidD   = r_valid_d;

`ifdef FETCH_PERF_EN
   localparam int unsigned CNT_W = 32;

   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   // A redirect overrides a stall, so only stalls that actually hold the PC are counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (StallF && !PCSrcE && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (FlushD && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

   assign StallCountF = r_stall_cnt;
   assign FlushCountD = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table, corner sequences and randomized run of fetch_stage
// against a cycle-level reference model of the fetch/decode handoff.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        StallF, StallD, FlushD, PCSrcE;
   logic [31:0] PCTargetE;
   logic [31:0] InstrF;
   logic [31:0] PCF, InstrD, PCD, PCPlus4D;
   logic        ValidD;
`ifdef FETCH_PERF_EN
   logic [31:0] StallCountF, FlushCountD;
`endif

   int n_pass  = 0;
   int n_total = 0;

   fetch_stage #(
      .DATA_WIDTH (32),
      .RESET_PC   (32'h0000_0000),
      .NOP_INSTR  (NOP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .StallF     (StallF),
      .StallD     (StallD),
      .FlushD     (FlushD),
      .PCSrcE     (PCSrcE),
      .PCTargetE  (PCTargetE),
      .InstrF     (InstrF),
`ifdef FETCH_PERF_EN
      .StallCountF(StallCountF),
      .FlushCountD(FlushCountD),
`endif
      .PCF        (PCF),
      .InstrD     (InstrD),
      .PCD        (PCD),
      .PCPlus4D   (PCPlus4D),
      .ValidD     (ValidD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: pure function of address, never equal to the NOP encoding.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A00_0001;
   endfunction

   assign InstrF = mem_word(PCF);

   // Reference model state
   logic [31:0] m_pc, m_pcd, m_pc4d;
   logic        m_valid;
   longint      m_stall_cnt, m_flush_cnt;

   function automatic logic [31:0] exp_instr(input logic v, input logic [31:0] pcd);
      return v ? mem_word(pcd) : NOP;
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_pcd = 32'h0; m_pc4d = 32'h0; m_valid = 1'b0;
      m_stall_cnt = 0; m_flush_cnt = 0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic chk_outputs(input string tag, input logic [31:0] e_pc, input logic [31:0] e_pcd,
                              input logic [31:0] e_pc4, input logic e_v);
      chk({tag, ".PCF"},      PCF,      e_pc);
      chk({tag, ".PCD"},      PCD,      e_pcd);
      chk({tag, ".PCPlus4D"}, PCPlus4D, e_pc4);
      chk({tag, ".ValidD"},   {31'b0, ValidD}, {31'b0, e_v});
      chk({tag, ".InstrD"},   InstrD,   exp_instr(e_v, e_pcd));
   endtask

   task automatic chk_model(input string tag);
      chk_outputs(tag, m_pc, m_pcd, m_pc4d, m_valid);
`ifdef FETCH_PERF_EN
      chk({tag, ".StallCountF"}, StallCountF, 32'(m_stall_cnt));
      chk({tag, ".FlushCountD"}, FlushCountD, 32'(m_flush_cnt));
`endif
   endtask

   // Apply one cycle of controls, advance the model by the fetch rules, sample 1ns after the edge.
   task automatic cycle(input logic sf, input logic sd, input logic fd, input logic ps,
                        input logic [31:0] tgt);
      logic [31:0] fetched_pc;
      StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
      @(posedge clk);
      fetched_pc = m_pc;
      if (fd) begin
         m_valid = 1'b0; m_pcd = 32'h0; m_pc4d = 32'h0;
      end else if (!sd) begin
         m_valid = 1'b1; m_pcd = fetched_pc; m_pc4d = fetched_pc + 32'd4;
      end
      if (ps)       m_pc = {tgt[31:2], 2'b00};
      else if (!sf) m_pc = fetched_pc + 32'd4;
      if (sf && !ps && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
      if (fd && m_flush_cnt < 64'hFFFF_FFFF)        m_flush_cnt++;
      #1;
   endtask

   typedef struct {
      logic        sf, sd, fd, ps;
      logic [31:0] tgt;
      logic [31:0] e_pc, e_pcd, e_pc4;
      logic        e_v;
   } vec_t;

   vec_t vecs[12];

   initial begin
      vecs[0]  = '{0,0,0,0, 32'h0,   32'h04,  32'h00, 32'h04, 1};
      vecs[1]  = '{0,0,0,0, 32'h0,   32'h08,  32'h04, 32'h08, 1};
      vecs[2]  = '{1,1,0,0, 32'h0,   32'h08,  32'h04, 32'h08, 1};
      vecs[3]  = '{1,1,0,0, 32'h0,   32'h08,  32'h04, 32'h08, 1};
      vecs[4]  = '{0,0,0,0, 32'h0,   32'h0C,  32'h08, 32'h0C, 1};
      vecs[5]  = '{0,0,0,0, 32'h0,   32'h10,  32'h0C, 32'h10, 1};
      vecs[6]  = '{0,0,1,1, 32'h40,  32'h40,  32'h00, 32'h00, 0};
      vecs[7]  = '{0,0,0,0, 32'h0,   32'h44,  32'h40, 32'h44, 1};
      vecs[8]  = '{0,0,0,1, 32'h43,  32'h40,  32'h44, 32'h48, 1};
      vecs[9]  = '{1,0,0,1, 32'h80,  32'h80,  32'h40, 32'h44, 1};
      vecs[10] = '{0,1,0,1, 32'h100, 32'h100, 32'h40, 32'h44, 1};
      vecs[11] = '{0,1,1,0, 32'h0,   32'h104, 32'h00, 32'h00, 0};

      rst = 1'b1;
      StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 32'h0;
      model_reset();
      #12;
      chk_outputs("reset", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_EN
      chk("reset.StallCountF", StallCountF, 32'h0);
      chk("reset.FlushCountD", FlushCountD, 32'h0);
`endif
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_outputs("release", 32'h0, 32'h0, 32'h0, 1'b0);

      for (int i = 0; i < 12; i++) begin
         cycle(vecs[i].sf, vecs[i].sd, vecs[i].fd, vecs[i].ps, vecs[i].tgt);
         chk_outputs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_pcd, vecs[i].e_pc4, vecs[i].e_v);
      end

      // PC wrap at the top of the address space
      cycle(0, 0, 1, 1, 32'hFFFF_FFFE);
      chk_outputs("wrap0", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
      cycle(0, 0, 0, 0, 32'h0);
      chk_outputs("wrap1", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);
      cycle(0, 0, 0, 0, 32'h0);
      chk_outputs("wrap2", 32'h4, 32'h0, 32'h4, 1'b1);

      // Asynchronous reset between edges during a stalled redirect
      StallF = 1; StallD = 1; PCSrcE = 1; PCTargetE = 32'h200;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk_outputs("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_EN
      chk("async_rst.StallCountF", StallCountF, 32'h0);
      chk("async_rst.FlushCountD", FlushCountD, 32'h0);
`endif
      @(negedge clk);
      rst = 1'b0;
      #1;

      // Event counters: three stalls then two flushes
      cycle(1, 1, 0, 0, 32'h0);
      cycle(1, 1, 0, 0, 32'h0);
      cycle(1, 0, 0, 0, 32'h0);
      cycle(0, 0, 1, 0, 32'h0);
      cycle(0, 0, 1, 0, 32'h0);
      chk_model("perf_seq");
`ifdef FETCH_PERF_EN
      chk("perf.StallCountF", StallCountF, 32'd3);
      chk("perf.FlushCountD", FlushCountD, 32'd2);
`endif

      // Randomized controls against the model
      for (int i = 0; i < 400; i++) begin
         logic [31:0] tgt;
         tgt = $urandom();
         if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
         cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), tgt);
         chk_model($sformatf("rand%0d", i));
         if (i == 200) begin
            @(negedge clk);
            #2;
            rst = 1'b1;
            #1;
            model_reset();
            chk_model("rand_rst");
            @(negedge clk);
            rst = 1'b0;
            #1;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
